reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, write-data width per requester.
REQ-002 Parameter: NREQ, 8, requester count; fixed at 8, matching the 3-bit register index.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  8  per-requester write request; level, held until granted.
REQ-006 Port: wdata  input  8*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 Port: gnt  output  8  one-hot grant pulse, registered.
REQ-008 Port: rf_we  output  1  register-file write enable, registered.
REQ-009 Port: rf_waddr  output  3  granted requester index, registered.
REQ-010 Port: rf_wsel  output  8  one-hot register select: decode of rf_waddr, gated by rf_we.
REQ-011 Port: rf_wdata  output  DATA_W  granted requester's data, registered.

Function
REQ-012 States: IDLE (no grant issued this cycle) and GRANT (one grant issued this cycle); LOCKED exists only per REQ-024.
REQ-013 Each cycle, the next state is GRANT if any req bit is 1, else IDLE.
REQ-014 Winner: the first asserted req bit searching upward from (ptr+1) mod 8, wrapping 7->0.
REQ-015 On a grant, the outputs register in the next cycle: gnt[w]=1, rf_we=1, rf_waddr=w, rf_wdata=wdata[w].
REQ-016 Latency is exactly 1 cycle from a sampled req to gnt/rf_we; throughput is one grant per cycle.
REQ-017 On a grant, ptr updates to w; ptr is unchanged while IDLE.
REQ-018 gnt is one-hot or all-zero, never multi-hot, and always equals rf_wsel.
REQ-019 With rf_we=0: rf_wsel=0, gnt=0, and rf_waddr/rf_wdata hold their last values.
REQ-020 A requester samples gnt[i]=1 and deasserts req[i] in the same cycle. If req[i] is still high at the next edge, the arbiter treats it as a new request.
REQ-021 If req[ptr] is the only request, the same requester wins again (back-to-back grants are allowed).

Reset
REQ-022 When rst=1 at an edge, state becomes IDLE, ptr=7 (so requester 0 has first priority), gnt=0, rf_we=0, rf_wsel=0, rf_waddr=0, rf_wdata=0.
REQ-023 A reset mid-grant cancels the pending write with no partial output. Requests during reset are ignored; arbitration resumes at the first edge after rst falls.

Configuration
REQ-024 Macro ARB_LOCK_EN adds input lock (8 bits) and state LOCKED.
REQ-025 With ARB_LOCK_EN: if the granted requester w has lock[w]=1 and req[w]=1, the next state is LOCKED and w is granted again, regardless of other requests.
REQ-026 LOCKED is left when lock[w]=0 or req[w]=0, then normal round-robin resumes from ptr=w.
REQ-027 Without ARB_LOCK_EN: the lock port and LOCKED state are absent, and behaviour is pure round-robin.

Structure
REQ-028 Shared package holds the NREQ=8 and index-width=3 constants, the state enum (IDLE, GRANT, LOCKED), and the reset pointer value 7.
REQ-029 Sub-module decoder_3_8 generates rf_wsel (sel=rf_waddr, En=rf_we). No other sub-modules.

Verification
REQ-030 Reset: rst=1 for 2 cycles with req=8'hFF -> gnt=0, rf_we=0, rf_wsel=0 throughout; the first grant after reset goes to index 0.
REQ-031 Rotation: req=8'hFF held for 8 cycles -> rf_waddr sequence 0,1,2,3,4,5,6,7, then wraps to 0; rf_wsel=8'h01,8'h02,...,8'h80.
REQ-032 Sparse requests with data: req=8'b1000_0100, wdata[2]=16'h1234, wdata[7]=16'hBEEF, ptr=1 -> grant index 2 with rf_wdata=16'h1234, next cycle index 7 with rf_wdata=16'hBEEF.
REQ-033 Idle and single requester: req=0 for 3 cycles -> rf_we=0, rf_wsel=0, ptr unchanged. Then req=8'h08 held for 2 cycles -> index 3 granted in both cycles.
REQ-034 Reset mid-operation: rst=1 in the cycle after req=8'h10 -> no write to index 4; after rst falls, the first grant is index 4 (pointer back at 7).
REQ-035 Lock, with ARB_LOCK_EN defined: req=8'h03, lock=8'h01 -> index 0 granted for 3 consecutive cycles; with lock=0, the next grant is index 1.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants, state encoding and round-robin search for reg_write_arbiter.
// Optional ARB_LOCK_EN build uses the LOCKED state.
package reg_write_arbiter_pkg;
    localparam int NREQ = 8;
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] PTR_RST = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Returns {found, index}. Scans from ptr+1 upward with wrap; offset 8 lands back on ptr.
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = ptr + IDX_W'(i);
            if (req[idx]) rr_pick = {1'b1, idx};
        end
    endfunction
endpackage

// File: rtl/reg_write_arbiter_decoder_3_8.sv
// 3-to-8 one-hot decoder with enable, drives the register-file select.
module decoder_3_8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] dec
);
    assign dec = en ? (8'd1 << sel) : 8'd0;
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter feeding a register file, one grant per cycle.
// Define ARB_LOCK_EN to add the lock input and the LOCKED state.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREQ   = reg_write_arbiter_pkg::NREQ
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   wdata,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]          lock,
`endif
    output logic [NREQ-1:0]          gnt,
    output logic                     rf_we,
    output logic [IDX_W-1:0]         rf_waddr,
    output logic [NREQ-1:0]          rf_wsel,
    output logic [DATA_W-1:0]        rf_wdata
);
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [IDX_W:0]     pick;
    logic [IDX_W-1:0]   win;
    logic               hold;

    always_comb begin
        pick    = rr_pick(req, ptr_q);
        hold    = 1'b0;
`ifdef ARB_LOCK_EN
        // ptr_q is the last winner; a locked, still-requesting winner keeps the bus
        hold    = (state_q != IDLE) && lock[ptr_q] && req[ptr_q];
`endif
        win     = hold ? ptr_q : pick[IDX_W-1:0];
        state_d = IDLE;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (hold || pick[IDX_W]) begin
            state_d = hold ? LOCKED : GRANT;
            ptr_d   = win;
            gnt_d   = NREQ'(1) << win;
            waddr_d = win;
            wdata_d = wdata[int'(win)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            gnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Write enable is simply "a grant was issued this cycle".
    assign rf_we    = (state_q != IDLE);
    assign gnt      = gnt_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

    decoder_3_8 u_dec (
        .sel (waddr_q),
        .en  (rf_we),
        .dec (rf_wsel)
    );
endmodule
